// File: rtl/adder_rsp_fifo_pkg.sv
// rtl/adder_rsp_fifo_pkg.sv - shared constants for the adder result queue
package adder_rsp_fifo_pkg;

    localparam int LEN_DATA      = 64;
    localparam int ADD_RSP_DEPTH = 4;

endpackage

// File: rtl/adder_rsp_fifo.sv
// rtl/adder_rsp_fifo.sv - FWFT queue capturing adder64 {sum, cout} results for a stallable consumer
module adder_rsp_fifo
    import adder_rsp_fifo_pkg::*;
#(
    parameter int W     = LEN_DATA,
    parameter int DEPTH = ADD_RSP_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_rdy,
    input  logic [W-1:0]  in_sum,
    input  logic          in_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_cout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [W:0]    mem_q [DEPTH];
    logic [W:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign out_sum   = mem_q[rd_ptr_q][W-1:0];
    assign out_cout  = mem_q[rd_ptr_q][W];
    assign ovf       = ovf_q;

    // A push while full is still accepted when the head leaves on the same edge.
    assign pop  = en & out_valid & out_ready;
    assign push = en & in_rdy & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (en & in_rdy & full & ~pop);
        if (push) begin
            mem_d[wr_ptr_q] = {in_cout, in_sum};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_adder_rsp_fifo.sv
// tb/tb_adder_rsp_fifo.sv - self-checking bench for adder_rsp_fifo against a queue reference model
module tb_adder_rsp_fifo;

    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          in_rdy = 1'b0;
    logic [W-1:0]  in_sum = '0;
    logic          in_cout = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] mq[$];
    bit         ovf_m = 1'b0;
    logic [W:0] sent[$];

    adder_rsp_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_rdy(in_rdy), .in_sum(in_sum),
        .in_cout(in_cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .count(count), .full(full),
        .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, (W+1)'(count), (W+1)'(mq.size()));
        chk({tag, ".empty"}, (W+1)'(empty), (W+1)'(mq.size() == 0));
        chk({tag, ".full"}, (W+1)'(full), (W+1)'(mq.size() == DEPTH));
        chk({tag, ".out_valid"}, (W+1)'(out_valid), (W+1)'(mq.size() != 0));
        chk({tag, ".ovf"}, (W+1)'(ovf), (W+1)'(ovf_m));
        if (mq.size() != 0) chk({tag, ".head"}, {out_cout, out_sum}, mq[0]);
    endtask

    // One clock: apply inputs, advance the reference model by the queue rules, then compare.
    task automatic cycle(input string tag, input bit r, input bit e, input bit rdy,
                         input logic [W-1:0] s, input bit c, input bit ordy);
        bit pop_m, push_m;
        rst = r; en = e; in_rdy = rdy; in_sum = s; in_cout = c; out_ready = ordy;
        pop_m  = e && (mq.size() > 0) && ordy;
        push_m = e && rdy && ((mq.size() < DEPTH) || pop_m);
        @(posedge clk);
        #1;
        if (!r) begin
            mq.delete();
            ovf_m = 1'b0;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (push_m) mq.push_back({c, s});
            if (e && rdy && !push_m) ovf_m = 1'b1;
        end
        check_all(tag);
    endtask

    initial begin
        int idx;
        int budget;
        bit rdy, ordy;
        logic [W-1:0] s;
        bit c;

        // Reset and idle
        for (int i = 0; i < 3; i++) cycle("reset", 0, 1, 0, '0, 0, 0);
        cycle("idle", 1, 1, 0, '0, 0, 0);
        chk("idle.out_sum", (W+1)'(out_sum), '0);
        chk("idle.out_cout", (W+1)'(out_cout), '0);
        chk("idle.count_const", (W+1)'(count), '0);

        // Single transfer
        cycle("single", 1, 1, 1, 64'h0000_0000_DEAD_BEEF, 1, 0);
        chk("single.sum_const", (W+1)'(out_sum), (W+1)'(64'hDEAD_BEEF));
        chk("single.cout_const", (W+1)'(out_cout), (W+1)'(1));
        chk("single.count_const", (W+1)'(count), (W+1)'(1));
        cycle("single_pop", 1, 1, 0, '0, 0, 1);
        chk("single_pop.empty_const", (W+1)'(empty), (W+1)'(1));

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            cycle("fill", 1, 1, 1, W'(i), 0, 0);
            if (i == 4) chk("fill.full_const", (W+1)'(full), (W+1)'(1));
        end
        chk("fill.ovf_const", (W+1)'(ovf), (W+1)'(1));
        for (int i = 1; i <= 4; i++) begin
            chk("drain.order_const", (W+1)'(out_sum), (W+1)'(i));
            cycle("drain", 1, 1, 0, '0, 0, 1);
        end
        chk("drain.empty_const", (W+1)'(empty), (W+1)'(1));
        chk("drain.ovf_sticky", (W+1)'(ovf), (W+1)'(1));

        // Simultaneous push and pop when full
        cycle("rst2", 0, 1, 0, '0, 0, 0);
        for (int i = 10; i <= 13; i++) cycle("fill2", 1, 1, 1, W'(i), 0, 0);
        cycle("pushpop", 1, 1, 1, W'(14), 0, 1);
        chk("pushpop.count_const", (W+1)'(count), (W+1)'(4));
        chk("pushpop.ovf_const", (W+1)'(ovf), '0);
        for (int i = 11; i <= 14; i++) begin
            chk("drain2.order_const", (W+1)'(out_sum), (W+1)'(i));
            cycle("drain2", 1, 1, 0, '0, 0, 1);
        end

        // Wrap-around streaming with random backpressure
        sent.delete();
        idx = 0;
        budget = 0;
        while (sent.size() < 20 && budget < 400) begin
            ordy = 1'($urandom_range(0, 1));
            rdy  = 1'($urandom_range(0, 1));
            if (mq.size() == DEPTH && !ordy) rdy = 1'b0;
            s = {$urandom, $urandom};
            c = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && ordy) begin
                chk("stream.order", {out_cout, out_sum}, sent[idx]);
                idx++;
            end
            if (rdy) sent.push_back({c, s});
            cycle("stream", 1, 1, rdy, s, c, ordy);
            budget++;
        end
        budget = 0;
        while (mq.size() > 0 && budget < 2 * DEPTH) begin
            chk("stream.order", {out_cout, out_sum}, sent[idx]);
            idx++;
            cycle("stream_drain", 1, 1, 0, '0, 0, 1);
            budget++;
        end
        chk("stream.popped", (W+1)'(idx), (W+1)'(20));
        chk("stream.ovf", (W+1)'(ovf), '0);

        // Enable low and reset mid-stream
        for (int i = 0; i < 3; i++) cycle("prefill", 1, 1, 1, W'(100 + i), 0, 0);
        for (int i = 0; i < 4; i++) cycle("en_low", 1, 0, 1, W'(200 + i), 1, 1);
        chk("en_low.count_const", (W+1)'(count), (W+1)'(3));
        chk("en_low.head_const", (W+1)'(out_sum), (W+1)'(100));
        cycle("mid_rst", 0, 1, 1, W'(300), 0, 1);
        chk("mid_rst.count_const", (W+1)'(count), '0);
        chk("mid_rst.valid_const", (W+1)'(out_valid), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_rsp_fifo.md
# adder_rsp_fifo

Result-side receiver for `adder64`. Captures every `{sum, cout}` word the adder presents with `rdy` high and holds it in a small first-word-fall-through queue. Presents the words in order to a downstream consumer over a valid/ready handshake. Sits between the adder output and the writeback/checker logic, so the consumer can stall while the adder keeps issuing results.

## Interface
Parameters:
- `W`, default `` `LEN_DATA ``: data width, equal to the adder `sum` width.
- `DEPTH`, default 4: queue entries. Must be a power of 2 and ≥ 2.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`.

Ports:
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst`  in  1: reset. Synchronous and active-low: state clears on a rising `clk` edge while `rst==0`.
- `en`  in  1: block enable. When 0, no push, no pop, all state held.
- `in_rdy`  in  1: adder result strobe, driven by `adder64.rdy`.
- `in_sum`  in  W: adder sum, driven by `adder64.sum`.
- `in_cout`  in  1: adder carry out, driven by `adder64.cout`.
- `out_valid`  out  1: head entry is available.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_sum`  out  W: head entry sum.
- `out_cout`  out  1: head entry carry.
- `count`  out  CW: number of occupied entries, 0..DEPTH.
- `full`  out  1: `count==DEPTH`.
- `empty`  out  1: `count==0`.
- `ovf`  out  1: sticky flag, set when a result is dropped.

## Operation
- Storage: DEPTH × (W+1) register array, plus write pointer, read pointer and `count`.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Push: `push = en & in_rdy & (~full | pop)`.
  - Writes `{in_cout, in_sum}` at the write pointer, then increments the write pointer.
- Pop: `pop = en & out_valid & out_ready`.
  - Increments the read pointer.
- The adder has no backpressure. A result arriving while full with no pop (`en & in_rdy & full & ~pop`) is dropped: no storage change and `ovf` is set.
  - `ovf` clears only on reset.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Push when full with a simultaneous pop is accepted. The popped entry leaves and the new entry enters the freed slot.
- Pop when empty is impossible because `out_valid` is low. `out_ready` is ignored when empty.
- `out_valid = ~empty`.
- `out_sum` and `out_cout` read the array at the read pointer (FWFT). Their value when empty is don't-care, but it must not be X after reset: the array resets to 0.
- `en==0`: `in_rdy` and `out_ready` are ignored and every register holds.
  - Outputs still reflect the held state. `out_valid` may stay high, but no transfer completes.

## Timing
- Reset (`rst==0` at a rising edge) clears, from the next cycle:
  - pointers to 0 and `count` to 0;
  - `empty=1`, `full=0`, `out_valid=0`, `ovf=0`;
  - `out_sum=0`, `out_cout=0`, and all array entries to 0.
- Reset overrides a same-edge push or pop. Reset mid-stream discards all queued entries.
- Latency: a result with `in_rdy` high at edge N appears on `out_*` with `out_valid=1` in the cycle after edge N. There is no combinational path from `in_*` to `out_*`.
- A pop at edge N presents the next entry in the cycle after edge N.
- `full`, `empty` and `count` are registered or derived from registered `count` only. There is no combinational dependence on `in_rdy` or `out_ready`.
- Sustained throughput is one result per cycle when `out_ready` is held high.

## Structure
- Constants go in `define/main.def.v`:
  - `LEN_DATA`, already present there;
  - new `` `ADD_RSP_DEPTH `` (4).
- Single module. No sub-module: the pointer/count logic is small enough to stay inline.
- The array is a plain reg array with a per-entry reset loop.

## Test plan
- Reset and idle:
  - hold `rst=0` for 3 cycles, then release with `en=1` and no `in_rdy`;
  - required: `empty=1`, `count=0`, `out_valid=0`, `ovf=0`, `out_sum=0`.
- Single transfer:
  - `in_rdy` for 1 cycle with `in_sum=64'h0000_0000_DEAD_BEEF`, `in_cout=1`, and `out_ready=0`;
  - required: next cycle `out_valid=1`, `out_sum=64'hDEAD_BEEF`, `out_cout=1`, `count=1`;
  - then `out_ready=1` for 1 cycle: required `empty=1` afterwards.
- Fill and overflow:
  - 5 consecutive pushes of sums 1..5 with `out_ready=0`;
  - required: after 4 pushes `full=1`; the 5th is dropped and `ovf=1`;
  - then drain with `out_ready=1`: outputs are 1,2,3,4 in order, then `empty=1`; `ovf` stays 1.
- Simultaneous push and pop when full:
  - fill with 10,11,12,13, then push 14 with `out_ready=1` in the same cycle;
  - required: `count` stays 4, `ovf=0`, and the drain order is 11,12,13,14.
- Wrap-around streaming:
  - 20 random pushes with `out_ready` randomly toggled, never exceeding depth;
  - required: the output sequence equals the input sequence and the pointers wrap without loss.
- `en` and reset mid-stream:
  - with 3 entries queued, drop `en` for 4 cycles while `in_rdy=1` and `out_ready=1`;
  - required: `count` stays 3 and the head is unchanged;
  - then assert `rst=0` for 1 cycle: required `count=0` and `out_valid=0` the next cycle.
